// File: rtl/jump_redirect_ctrl_if.sv
// jump_redirect_ctrl_if: pipeline-side request/redirect bundle for the jump redirect controller
interface jump_redirect_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic            stall_f;
  logic            jump_d;
  logic            jump_reg_d;
  logic            rs_busy_d;
  logic [PC_W-1:0] jump_target_d;
  logic            branch_taken_e;
  logic [PC_W-1:0] branch_target_e;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_d;
  logic            flush_e;
  logic            stall_jr;
  logic [CNT_W-1:0] jump_count;
  logic [CNT_W-1:0] jr_stall_cycles;
  modport master (
    output stall_f, jump_d, jump_reg_d, rs_busy_d, jump_target_d, branch_taken_e, branch_target_e,
    input  redirect_valid, redirect_pc, flush_d, flush_e, stall_jr, jump_count, jr_stall_cycles
  );
  modport slave (
    input  stall_f, jump_d, jump_reg_d, rs_busy_d, jump_target_d, branch_taken_e, branch_target_e,
    output redirect_valid, redirect_pc, flush_d, flush_e, stall_jr, jump_count, jr_stall_cycles
  );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: arbitrates EX branch vs ID jump/jr redirects, holds redirects over fetch stalls
module jump_redirect_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  jump_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, JR_WAIT, PENDING} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pend_pc, pend_pc_nx, rpc;
  logic pend_src, pend_src_nx;
  logic branch, jump, jr_hold;
  logic rv, fd, fe, sjr, cnt_jump;
  logic [CNT_W-1:0] jump_count, jr_stall_cycles;
  assign branch  = bus.branch_taken_e;
  assign jump    = (bus.jump_reg_d ? ~bus.rs_busy_d : bus.jump_d) & ~branch;
  assign jr_hold = bus.jump_reg_d & bus.rs_busy_d & ~branch;
  always_comb begin
    state_nx    = state;
    pend_pc_nx  = pend_pc;
    pend_src_nx = pend_src;
    rv          = 1'b0;
    rpc         = '0;
    fd          = 1'b0;
    fe          = 1'b0;
    sjr         = 1'b0;
    cnt_jump    = 1'b0;
    if (state == PENDING) begin
      if (branch) begin
        pend_pc_nx  = bus.branch_target_e;
        pend_src_nx = 1'b0;
        fd          = 1'b1;
        fe          = 1'b1;
      end else if (!bus.stall_f) begin
        rv       = 1'b1;
        rpc      = pend_pc;
        cnt_jump = pend_src;
        state_nx = IDLE;
      end
    end else if (branch || jump) begin
      fd = 1'b1;
      fe = branch;
      if (bus.stall_f) begin
        state_nx    = PENDING;
        pend_pc_nx  = branch ? bus.branch_target_e : bus.jump_target_d;
        pend_src_nx = jump;
      end else begin
        rv       = 1'b1;
        rpc      = branch ? bus.branch_target_e : bus.jump_target_d;
        cnt_jump = jump;
        state_nx = IDLE;
      end
    end else if (jr_hold) begin
      sjr      = 1'b1;
      fe       = 1'b1;
      state_nx = JR_WAIT;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pend_pc         <= '0;
      pend_src        <= 1'b0;
      jump_count      <= '0;
      jr_stall_cycles <= '0;
    end else begin
      state    <= state_nx;
      pend_pc  <= pend_pc_nx;
      pend_src <= pend_src_nx;
      if (cnt_jump && !(&jump_count)) jump_count <= jump_count + CNT_W'(1);
      if (sjr && !(&jr_stall_cycles)) jr_stall_cycles <= jr_stall_cycles + CNT_W'(1);
    end
  end
  // reset holds every control output low regardless of what the pipeline presents
  assign bus.redirect_valid  = rst_n & rv;
  assign bus.redirect_pc     = rst_n ? rpc : '0;
  assign bus.flush_d         = rst_n & fd;
  assign bus.flush_e         = rst_n & fe;
  assign bus.stall_jr        = rst_n & sjr;
  assign bus.jump_count      = jump_count;
  assign bus.jr_stall_cycles = jr_stall_cycles;
  a_jump_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.jump_d && bus.jump_reg_d));
endmodule
